adder_with_flow_control: RTL and testbench

ADDER_WITH_FLOW_CONTROL -- requirements
Module: adder_with_flow_control

---
 rtl/adder_with_flow_control_pkg.sv | 12 +
 rtl/adder_with_flow_control_fifo.sv | 57 +++++
 rtl/adder_with_flow_control.sv | 81 ++++++++
 tb/tb_adder_with_flow_control.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_with_flow_control_pkg.sv
// Shared constants and helpers for the flow-controlled adder.
// Default operand width / FIFO depth and pointer sizing.
package adder_with_flow_control_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/adder_with_flow_control_fifo.sv
// Valid/ready FIFO used for each operand stream.
// Ready depends on occupancy only; async active-low reset.
import adder_with_flow_control_pkg::*;

module flow_control_fifo #(
  parameter int W = DEF_WIDTH,
  parameter int D = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam int PW = ptr_w(D);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(D);

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;

  assign in_ready  = rst & (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_ready & out_valid;
  assign out_data  = mem[rd_ptr];

  // storage write on accepted push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // pointers wrap naturally (power-of-two depth), count tracks fill
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adder_with_flow_control.sv
// Adds paired operands from two independent valid/ready streams.
// ADDER_WFC_OUT_REG_EN selects a registered output stage.
import adder_with_flow_control_pkg::*;

module adder_with_flow_control #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [WIDTH:0]   sum_data
);

  logic             a_hv;
  logic             b_hv;
  logic [WIDTH-1:0] a_hd;
  logic [WIDTH-1:0] b_hd;
  logic             pair_v;
  logic             pop;
  logic [WIDTH:0]   sum_w;

  flow_control_fifo #(.W(WIDTH), .D(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_valid),
    .in_ready  (a_ready),
    .in_data   (a_data),
    .out_valid (a_hv),
    .out_ready (pop),
    .out_data  (a_hd)
  );

  flow_control_fifo #(.W(WIDTH), .D(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_valid),
    .in_ready  (b_ready),
    .in_data   (b_data),
    .out_valid (b_hv),
    .out_ready (pop),
    .out_data  (b_hd)
  );

  assign pair_v = a_hv & b_hv;
  assign sum_w  = {1'b0, a_hd} + {1'b0, b_hd};

`ifdef ADDER_WFC_OUT_REG_EN
  logic           out_v;
  logic [WIDTH:0] out_d;

  assign pop       = pair_v & (~out_v | sum_ready);
  assign sum_valid = out_v;
  assign sum_data  = out_d;

  // output stage: load on pair pop, empty when drained without refill
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_v <= 1'b0;
      out_d <= '0;
    end else if (pop) begin
      out_v <= 1'b1;
      out_d <= sum_w;
    end else if (sum_ready) begin
      out_v <= 1'b0;
    end
  end
`else
  assign pop       = pair_v & sum_ready;
  assign sum_valid = pair_v;
  assign sum_data  = pair_v ? sum_w : '0;
`endif

endmodule

// File: tb/tb_adder_with_flow_control.sv
// Self-checking bench for adder_with_flow_control.
// Vector table, directed corner sequences and a queue scoreboard.
module tb_adder_with_flow_control;

  localparam int W = 4;
  localparam int D = 4;
`ifdef ADDER_WFC_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int OREG = LAT - 1;

  logic         clk;
  logic         rst;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] a_data;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] b_data;
  logic         sum_valid;
  logic         sum_ready;
  logic [W:0]   sum_data;

  adder_with_flow_control #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int n_a;
  int n_b;
  int n_s;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  bit         hold_v;
  logic [W:0] hold_d;
  logic [W:0] mon_e;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   s;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record transfers seen just before each rising edge
  always @(negedge clk) begin
    if (rst) begin
      if (hold_v) begin
        chk("sum_hold_valid", 32'(sum_valid), 32'd1);
        chk("sum_hold_data", 32'(sum_data), 32'(hold_d));
      end
      if (sum_valid && sum_ready) begin
        if (qa.size() == 0 || qb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sum_spurious got=%0h want=none", sum_data);
        end else begin
          mon_e = {1'b0, qa.pop_front()} + {1'b0, qb.pop_front()};
          chk("sum_order", 32'(sum_data), 32'(mon_e));
        end
        n_s++;
      end
      if (a_valid && a_ready) begin
        qa.push_back(a_data);
        n_a++;
      end
      if (b_valid && b_ready) begin
        qb.push_back(b_data);
        n_b++;
      end
      hold_v = sum_valid && !sum_ready;
      hold_d = sum_data;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic apply_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W:0] s);
    sum_ready = 1'b1;
    a_data  = a;
    b_data  = b;
    a_valid = 1'b1;
    b_valid = 1'b1;
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
`ifdef ADDER_WFC_OUT_REG_EN
    chk("vec_early", 32'(sum_valid), 32'd0);
    step();
`endif
    chk("vec_valid", 32'(sum_valid), 32'd1);
    chk("vec_sum", 32'(sum_data), 32'(s));
    step();
    chk("vec_drained", 32'(sum_valid), 32'd0);
  endtask

  task automatic send_b();
    bit got;
    int tries;
    got = 1'b0;
    tries = 0;
    b_valid = 1'b1;
    b_data  = W'($urandom);
    do begin
      @(negedge clk);
      got = b_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!got && tries < 50);
    b_valid = 1'b0;
    chk("send_b_timeout", 32'(got), 32'd1);
  endtask

  int a0;
  int b0;
  int s0;
  int cyc;

  initial begin
    checks = 0;
    failures = 0;
    n_a = 0;
    n_b = 0;
    n_s = 0;
    hold_v = 1'b0;
    rst = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data = '0;
    b_data = '0;
    sum_ready = 1'b0;

    tbl[0] = '{4'd3,  4'd5,  5'd8};
    tbl[1] = '{4'hF,  4'hF,  5'h1E};
    tbl[2] = '{4'd0,  4'd0,  5'd0};
    tbl[3] = '{4'hF,  4'd0,  5'hF};
    tbl[4] = '{4'd7,  4'd9,  5'h10};
    tbl[5] = '{4'd1,  4'd14, 5'hF};
    tbl[6] = '{4'd8,  4'd8,  5'h10};

    #12;
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_sum_valid", 32'(sum_valid), 32'd0);
    chk("rst_sum_data", 32'(sum_data), 32'd0);
    #10 rst = 1'b1;
    step();
    chk("post_rst_a_ready", 32'(a_ready), 32'd1);
    chk("post_rst_b_ready", 32'(b_ready), 32'd1);

    for (int i = 0; i < 7; i++) apply_vec(tbl[i].a, tbl[i].b, tbl[i].s);

    // back-to-back stream
    a0 = n_a;
    b0 = n_b;
    s0 = n_s;
    sum_ready = 1'b1;
    a_data = 4'd3;
    b_data = 4'd5;
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      a_data = W'($urandom);
      b_data = W'($urandom);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("b2b_acc_a", 32'(n_a - a0), 32'd20);
    chk("b2b_acc_b", 32'(n_b - b0), 32'd20);
    chk("b2b_sums", 32'(n_s - s0), 32'(20 - LAT));
    repeat (4) step();
    chk("b2b_total", 32'(n_s - s0), 32'd20);

    // only A offered
    a0 = n_a;
    s0 = n_s;
    a_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_data = W'($urandom);
      step();
    end
    a_valid = 1'b0;
    chk("onlya_acc", 32'(n_a - a0), 32'(D));
    chk("onlya_ready", 32'(a_ready), 32'd0);
    chk("onlya_no_sum", 32'(sum_valid), 32'd0);
    chk("onlya_sums", 32'(n_s - s0), 32'd0);
    for (int i = 0; i < D; i++) send_b();
    repeat (6) step();
    chk("onlya_drain", 32'(n_s - s0), 32'(D));
    chk("onlya_qa_empty", 32'(qa.size()), 32'd0);

    // backpressure
    a0 = n_a;
    b0 = n_b;
    s0 = n_s;
    sum_ready = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_data = W'($urandom);
      b_data = W'($urandom);
      step();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("bp_acc_a", 32'(n_a - a0), 32'(D + OREG));
    chk("bp_acc_b", 32'(n_b - b0), 32'(D + OREG));
    chk("bp_a_ready", 32'(a_ready), 32'd0);
    chk("bp_b_ready", 32'(b_ready), 32'd0);
    chk("bp_sum_valid", 32'(sum_valid), 32'd1);
    sum_ready = 1'b1;
    repeat (2 * D + 3) step();
    chk("bp_drain", 32'(n_s - s0), 32'(D + OREG));
    chk("bp_empty_valid", 32'(sum_valid), 32'd0);

    // random traffic, 100 transfers per stream
    a0 = n_a;
    b0 = n_b;
    s0 = n_s;
    cyc = 0;
    while ((n_a - a0 < 100 || n_b - b0 < 100) && cyc < 3000) begin
      a_valid = (n_a - a0 < 100) && ($urandom_range(0, 1) == 1);
      b_valid = (n_b - b0 < 100) && ($urandom_range(0, 1) == 1);
      a_data = W'($urandom);
      b_data = W'($urandom);
      sum_ready = ($urandom_range(0, 1) == 1);
      step();
      cyc++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    sum_ready = 1'b1;
    repeat (2 * D + 3) step();
    chk("rnd_acc_a", 32'(n_a - a0), 32'd100);
    chk("rnd_acc_b", 32'(n_b - b0), 32'd100);
    chk("rnd_sums", 32'(n_s - s0), 32'd100);
    chk("rnd_qa_empty", 32'(qa.size()), 32'd0);
    chk("rnd_qb_empty", 32'(qb.size()), 32'd0);
    chk("rnd_idle", 32'(sum_valid), 32'd0);

    // reset while operands and a sum are pending
    sum_ready = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data = 4'd9;
    b_data = 4'd4;
    step();
    step();
    b_valid = 1'b0;
    step();
    a_valid = 1'b0;
    chk("mid_pending", 32'(sum_valid), 32'd1);
    #3 rst = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    chk("mid_rst_valid", 32'(sum_valid), 32'd0);
    chk("mid_rst_data", 32'(sum_data), 32'd0);
    chk("mid_rst_ready", 32'(a_ready), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    step();
    chk("mid_post_ready", 32'(a_ready & b_ready), 32'd1);
    apply_vec(4'd2, 4'd6, 5'd8);
    chk("mid_qa_empty", 32'(qa.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
